// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types for the half-bridge pwm dead-time stage
package pwm_pkg;

  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } _pwm_onoff;

  // One-hot so each gate decode is a single state bit.
  typedef enum logic [4:0] {
    OFF   = 5'b00001,
    H_ON  = 5'b00010,
    DT_HL = 5'b00100,
    L_ON  = 5'b01000,
    DT_LH = 5'b10000
  } dt_state_e;

  localparam int DT_WIDTH_DEF = 10;

endpackage

// File: rtl/pwm_deadtime_gen_if.sv
// rtl/pwm_deadtime_gen_if.sv - pwm request in, complementary gate pair out
interface pwm_deadtime_gen_if #(
  parameter int DT_WIDTH = pwm_pkg::DT_WIDTH_DEF
);
  import pwm_pkg::*;

  logic                pwm_in;
  _pwm_onoff           pwm_onoff;
  logic [DT_WIDTH-1:0] dt_rise;
  logic [DT_WIDTH-1:0] dt_fall;
  logic                pwm_h;
  logic                pwm_l;
  logic                dt_active;

  modport master (
    output pwm_in, pwm_onoff, dt_rise, dt_fall,
    input  pwm_h, pwm_l, dt_active
  );

  modport slave (
    input  pwm_in, pwm_onoff, dt_rise, dt_fall,
    output pwm_h, pwm_l, dt_active
  );

endinterface

// File: rtl/pwm_deadtime_gen.sv
// rtl/pwm_deadtime_gen.sv - break-before-make dead-time generator for one half-bridge leg
module pwm_deadtime_gen
  import pwm_pkg::*;
#(
  parameter int DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  pwm_deadtime_gen_if.slave  leg
);

  localparam logic [DT_WIDTH-1:0] CNT_ONE = {{(DT_WIDTH-1){1'b0}}, 1'b1};

  logic                r_pwm_q;
  dt_state_e           r_state;
  logic [DT_WIDTH-1:0] r_cnt;
  logic                r_pwm_h;
  logic                r_pwm_l;
  logic                r_dt_active;

  dt_state_e           w_nxt_state;
  logic [DT_WIDTH-1:0] w_nxt_cnt;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    if (leg.pwm_onoff == PWM_OFF) begin
      w_nxt_state = OFF;
      w_nxt_cnt   = '0;
    end else begin
      case (r_state)
        OFF: begin
          // First turn-on always pays a full dead time toward the requested side.
          if (r_pwm_q) begin
            w_nxt_state = DT_LH;
            w_nxt_cnt   = leg.dt_rise;
          end else begin
            w_nxt_state = DT_HL;
            w_nxt_cnt   = leg.dt_fall;
          end
        end
        H_ON: begin
          if (!r_pwm_q) begin
            w_nxt_state = DT_HL;
            w_nxt_cnt   = leg.dt_fall;
          end
        end
        L_ON: begin
          if (r_pwm_q) begin
            w_nxt_state = DT_LH;
            w_nxt_cnt   = leg.dt_rise;
          end
        end
        DT_HL: begin
          // Abort wins over expiry: the low side has not yet been driven.
          if (r_pwm_q)            w_nxt_state = H_ON;
          else if (r_cnt == '0)   w_nxt_state = L_ON;
          else                    w_nxt_cnt   = r_cnt - CNT_ONE;
        end
        DT_LH: begin
          if (!r_pwm_q)           w_nxt_state = L_ON;
          else if (r_cnt == '0)   w_nxt_state = H_ON;
          else                    w_nxt_cnt   = r_cnt - CNT_ONE;
        end
        default: begin
          w_nxt_state = OFF;
          w_nxt_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_q     <= 1'b0;
      r_state     <= OFF;
      r_cnt       <= '0;
      r_pwm_h     <= 1'b0;
      r_pwm_l     <= 1'b0;
      r_dt_active <= 1'b0;
    end else begin
      r_pwm_q     <= leg.pwm_in;
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_pwm_h     <= (w_nxt_state == H_ON);
      r_pwm_l     <= (w_nxt_state == L_ON);
      r_dt_active <= (w_nxt_state == DT_HL) || (w_nxt_state == DT_LH);
    end
  end

  assign leg.pwm_h     = r_pwm_h;
  assign leg.pwm_l     = r_pwm_l;
  assign leg.dt_active = r_dt_active;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// tb/tb_pwm_deadtime_gen.sv - scoreboard bench for pwm_deadtime_gen against a side/gap model
module tb_pwm_deadtime_gen;

  localparam int DTW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pwm_deadtime_gen_if #(.DT_WIDTH(DTW)) leg ();

  pwm_deadtime_gen #(.DT_WIDTH(DTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .leg   (leg.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic h;
    logic l;
    logic dta;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void chk(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, act, req);
    end
  endfunction

  // Model: which gate is on (0 none, 1 high, 2 low), remaining gap cycles (-1 = no gap),
  // and which side the gap is heading to. Decisions use the one-cycle-old pwm_in.
  int   m_side;
  int   m_gap;
  int   m_want;
  logic m_q;

  always @(posedge clk or negedge rst_n) begin : model
    int req;
    if (!rst_n) begin
      m_side = 0;
      m_gap  = -1;
      m_want = 0;
      m_q    = 1'b0;
      exp_q.delete();
    end else begin
      req = m_q ? 1 : 2;
      if (leg.pwm_onoff == pwm_pkg::PWM_OFF) begin
        m_side = 0;
        m_gap  = -1;
      end else if (m_gap >= 0) begin
        if (req != m_want) begin
          m_side = req;
          m_gap  = -1;
        end else if (m_gap == 0) begin
          m_side = m_want;
          m_gap  = -1;
        end else begin
          m_gap = m_gap - 1;
        end
      end else if (m_side != req) begin
        m_side = 0;
        m_want = req;
        m_gap  = m_q ? int'(leg.dt_rise) : int'(leg.dt_fall);
      end
      m_q = leg.pwm_in;
      exp_q.push_back('{m_side == 1, m_side == 2, m_gap >= 0});
    end
  end

  logic prev_h = 1'b0;
  logic prev_l = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = '{1'b0, 1'b0, 1'b0};
    chk("pwm_h", leg.pwm_h, e.h);
    chk("pwm_l", leg.pwm_l, e.l);
    chk("dt_active", leg.dt_active, e.dta);
    if ((leg.pwm_h && !prev_h) || (leg.pwm_l && !prev_l))
      chk("gap_before_turn_on", prev_h || prev_l, 1'b0);
    prev_h = leg.pwm_h;
    prev_l = leg.pwm_l;
  end

  always @(leg.pwm_h or leg.pwm_l) begin
    chk("gates_exclusive", leg.pwm_h && leg.pwm_l, 1'b0);
  end

  task automatic drive(input logic pin, input logic on, input int dr, input int df, input int n);
    leg.pwm_in    = pin;
    leg.pwm_onoff = on ? pwm_pkg::PWM_ON : pwm_pkg::PWM_OFF;
    leg.dt_rise   = DTW'(dr);
    leg.dt_fall   = DTW'(df);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    leg.pwm_in    = 1'b0;
    leg.pwm_onoff = pwm_pkg::PWM_OFF;
    leg.dt_rise   = '0;
    leg.dt_fall   = '0;
    repeat (3) @(negedge clk);
    chk("reset_h", leg.pwm_h, 1'b0);
    chk("reset_l", leg.pwm_l, 1'b0);
    chk("reset_dta", leg.dt_active, 1'b0);
    rst_n = 1'b1;

    // enable with high request, dt_rise = 5
    drive(1'b1, 1'b0, 5, 3, 2);
    drive(1'b1, 1'b1, 5, 3, 12);
    chk("t1_h_on", leg.pwm_h, 1'b1);
    // fall with dt_fall = 3
    drive(1'b0, 1'b1, 5, 3, 10);
    chk("t2_l_on", leg.pwm_l, 1'b1);
    // zero dead time, toggling every 4 cycles
    for (int i = 0; i < 8; i++) drive(i[0] ? 1'b0 : 1'b1, 1'b1, 0, 0, 4);
    // glitch abort with dt_fall = 10
    drive(1'b1, 1'b1, 0, 10, 15);
    drive(1'b0, 1'b1, 0, 10, 2);
    drive(1'b1, 1'b1, 0, 10, 12);
    chk("t4_h_back", leg.pwm_h, 1'b1);
    // disable during DT_LH, then re-enable
    drive(1'b0, 1'b1, 10, 10, 15);
    drive(1'b1, 1'b1, 10, 10, 4);
    drive(1'b1, 1'b0, 10, 10, 3);
    drive(1'b1, 1'b1, 10, 10, 15);
    // async reset while high side is on
    chk("t6_pre_h", leg.pwm_h, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_h", leg.pwm_h, 1'b0);
    chk("t6_async_l", leg.pwm_l, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 4, 6, 20);

    for (int s = 0; s < 300; s++) begin
      int dr;
      int df;
      dr = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 30)) : int'($urandom_range(0, 6));
      df = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 30)) : int'($urandom_range(0, 6));
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 15) != 0), dr, df,
            int'($urandom_range(1, 12)));
    end

    drive(1'b0, 1'b0, 0, 0, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
